// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Active driver for a 4x4 matrix keypad. Columns are driven low one at a
// time; after a settle delay the synchronized rows are sampled. A detected
// press is debounced, reported once as a key code over a valid/ready
// handshake, and then the scanner waits for a debounced release before it
// moves on to the next column.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  asynchronous reset, active-low
//   row_n      in   4  keypad rows, active-low, asynchronous to clk
//   col_n      out  4  column drive, one-hot active-low; 4'b1111 = none driven
//   key_code   out  4  {row_idx[1:0], col_idx[1:0]}; meaningful while key_valid
//   key_valid  out  1  key_code available; held until accepted
//   key_ready  in   1  consumer accepts key_code on key_valid && key_ready
//   busy       out  1  high whenever the scanner is not actively scanning
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SETTLE_CYC   = 27,
  parameter int DEBOUNCE_CYC = 270_000,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       busy
);

  localparam logic [2:0] SCAN_DRIVE   = 3'd0;
  localparam logic [2:0] SCAN_SAMPLE  = 3'd1;
  localparam logic [2:0] DEBOUNCE     = 3'd2;
  localparam logic [2:0] REPORT       = 3'd3;
  localparam logic [2:0] WAIT_RELEASE = 3'd4;

  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = '0;

  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_sync_q, row_sync_d;
  logic [2:0]       state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       pattern_q, pattern_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [3:0]       rows;
  logic             rows_idle;

  assign rows      = row_sync_q;
  assign rows_idle = (rows == 4'b1111);

  // Next-state logic. One counter is shared between the settle delay, the
  // press debounce and the release debounce since only one is ever active.
  // The column drive is computed from the next column index so the pins
  // change on the same edge as the index and the settle delay covers the
  // synchronizer latency for the newly driven column.
  always_comb begin
    row_meta_d  = row_n;
    row_sync_d  = row_meta_q;
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    row_idx_d   = row_idx_q;
    pattern_d   = pattern_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;

    case (state_q)
      SCAN_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = SCAN_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      SCAN_SAMPLE: begin
        cnt_d = CNT_ZERO;
        if (rows_idle) begin
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN_DRIVE;
        end else begin
          // Several keys in one column: the lowest-numbered row wins.
          if (!rows[0]) begin
            row_idx_d = 2'd0;
          end else if (!rows[1]) begin
            row_idx_d = 2'd1;
          end else if (!rows[2]) begin
            row_idx_d = 2'd2;
          end else begin
            row_idx_d = 2'd3;
          end
          pattern_d = rows;
          state_d   = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (rows != pattern_q) begin
          cnt_d   = CNT_ZERO;
          state_d = SCAN_DRIVE;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          cnt_d       = CNT_ZERO;
          key_code_d  = {row_idx_q, col_idx_q};
          key_valid_d = 1'b1;
          state_d     = REPORT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      REPORT: begin
        if (key_valid_q && key_ready) begin
          key_valid_d = 1'b0;
          cnt_d       = CNT_ZERO;
          state_d     = WAIT_RELEASE;
        end
      end

      WAIT_RELEASE: begin
        // Any low row restarts the release qualification, so a release that
        // happened while the consumer stalled still has to be re-confirmed.
        if (!rows_idle) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          cnt_d     = CNT_ZERO;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN_DRIVE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d       = CNT_ZERO;
        key_valid_d = 1'b0;
        state_d     = SCAN_DRIVE;
      end
    endcase

    col_n_d = ~(4'b0001 << col_idx_d);
  end

  // State registers. Reset parks the column drive at all-high so no column
  // is driven until the scanner is running again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      state_q     <= SCAN_DRIVE;
      col_idx_q   <= 2'd0;
      cnt_q       <= CNT_ZERO;
      row_idx_q   <= 2'd0;
      pattern_q   <= 4'b1111;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      col_n_q     <= 4'b1111;
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      row_idx_q   <= row_idx_d;
      pattern_q   <= pattern_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      col_n_q     <= col_n_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign busy      = (state_q != SCAN_DRIVE) && (state_q != SCAN_SAMPLE);

endmodule
